// File: rtl/sha256_id_validator.sv
// Joins expected packet IDs with tagged SHA-256 digests and flags tag mismatches.
// Define SHA256_ID_VALIDATOR_LAST_CHECK_EN to also track last-marker mismatches.
module sha256_id_validator #(
    parameter int ID_W   = 6,
    parameter int HASH_W = 256,
    parameter int CNT_W  = 10
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              en,
    input  logic              sync_rst,
    input  logic [ID_W-1:0]   id_in_buf,
    input  logic              id_in_buf_last,
    input  logic              id_in_buf_valid,
    output logic              id_in_buf_ready,
    input  logic [HASH_W-1:0] hash_in,
    input  logic [ID_W-1:0]   hash_in_id,
    input  logic              hash_in_last,
    input  logic              hash_in_valid,
    output logic              hash_in_ready,
    output logic [HASH_W-1:0] hash_out,
    output logic              hash_out_err,
    output logic              hash_out_last,
    output logic              hash_out_valid,
    input  logic              hash_out_ready,
    output logic [1:0]        status_err,
    output logic [CNT_W-1:0]  status_packet_count,
    input  logic              status_clear
);

    logic       slot;
    logic       live;
    logic       join_fire;
    logic       out_fire;
    logic       id_mis;
    logic       last_mis;
    logic [1:0] flags;

    assign slot = !hash_out_valid | hash_out_ready;
    assign live = nrst & en & !sync_rst & slot;

    assign id_in_buf_ready = live & hash_in_valid;
    assign hash_in_ready   = live & id_in_buf_valid;

    assign join_fire = live & hash_in_valid & id_in_buf_valid;
    assign out_fire  = en & hash_out_valid & hash_out_ready;

    assign id_mis = (hash_in_id != id_in_buf);

`ifdef SHA256_ID_VALIDATOR_LAST_CHECK_EN
    assign last_mis = (id_in_buf_last != hash_in_last);
`else
    // The ID-buffer last marker only matters when the last check is built.
    logic unused_last;
    assign unused_last = id_in_buf_last;
    assign last_mis    = 1'b0;
`endif

    assign flags = {last_mis, id_mis};

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            hash_out       <= '0;
            hash_out_err   <= 1'b0;
            hash_out_last  <= 1'b0;
            hash_out_valid <= 1'b0;
        end else if (sync_rst) begin
            hash_out       <= '0;
            hash_out_err   <= 1'b0;
            hash_out_last  <= 1'b0;
            hash_out_valid <= 1'b0;
        end else if (join_fire) begin
            hash_out       <= hash_in;
            hash_out_err   <= id_mis;
            hash_out_last  <= hash_in_last;
            hash_out_valid <= 1'b1;
        end else if (out_fire) begin
            hash_out_valid <= 1'b0;
        end
    end

    // A clear coinciding with a join leaves only that join's contribution.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            status_err          <= 2'b00;
            status_packet_count <= '0;
        end else if (sync_rst) begin
            status_err          <= 2'b00;
            status_packet_count <= '0;
        end else if (status_clear) begin
            status_err          <= join_fire ? flags : 2'b00;
            status_packet_count <= join_fire ? CNT_W'(1) : '0;
        end else if (join_fire) begin
            status_err          <= status_err | flags;
            status_packet_count <= status_packet_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_sha256_id_validator.sv
// Self-checking bench for sha256_id_validator: directed steps then random traffic.
// Expected values come from a transaction-level model of the join and status rules.
module tb_sha256_id_validator;

    logic         clk = 1'b0;
    logic         nrst;
    logic         en;
    logic         sync_rst;
    logic [5:0]   id_in_buf;
    logic         id_in_buf_last;
    logic         id_in_buf_valid;
    logic         id_in_buf_ready;
    logic [255:0] hash_in;
    logic [5:0]   hash_in_id;
    logic         hash_in_last;
    logic         hash_in_valid;
    logic         hash_in_ready;
    logic [255:0] hash_out;
    logic         hash_out_err;
    logic         hash_out_last;
    logic         hash_out_valid;
    logic         hash_out_ready;
    logic [1:0]   status_err;
    logic [9:0]   status_packet_count;
    logic         status_clear;

    int checks = 0;
    int errors = 0;

    logic         m_valid;
    logic [255:0] m_hash;
    logic         m_err;
    logic         m_last;
    int           m_cnt;
    logic [1:0]   m_serr;
    logic         joined;
    logic [255:0] p2_hash;

    always #5 clk = ~clk;

    sha256_id_validator dut (
        .clk                 (clk),
        .nrst                (nrst),
        .en                  (en),
        .sync_rst            (sync_rst),
        .id_in_buf           (id_in_buf),
        .id_in_buf_last      (id_in_buf_last),
        .id_in_buf_valid     (id_in_buf_valid),
        .id_in_buf_ready     (id_in_buf_ready),
        .hash_in             (hash_in),
        .hash_in_id          (hash_in_id),
        .hash_in_last        (hash_in_last),
        .hash_in_valid       (hash_in_valid),
        .hash_in_ready       (hash_in_ready),
        .hash_out            (hash_out),
        .hash_out_err        (hash_out_err),
        .hash_out_last       (hash_out_last),
        .hash_out_valid      (hash_out_valid),
        .hash_out_ready      (hash_out_ready),
        .status_err          (status_err),
        .status_packet_count (status_packet_count),
        .status_clear        (status_clear)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic model_clear();
        m_valid = 1'b0;
        m_hash  = '0;
        m_err   = 1'b0;
        m_last  = 1'b0;
        m_cnt   = 0;
        m_serr  = 2'b00;
    endtask

    // One clock: inputs are already driven just after a negedge.
    task automatic tick();
        logic         slot;
        logic         jn;
        logic         ofire;
        logic [1:0]   fl;
        logic [255:0] h;
        logic         hl;
        #1;
        slot = !m_valid | hash_out_ready;
        chk("id_ready", 256'(id_in_buf_ready),
            256'(nrst & en & !sync_rst & hash_in_valid & slot));
        chk("hash_ready", 256'(hash_in_ready),
            256'(nrst & en & !sync_rst & id_in_buf_valid & slot));
        jn    = nrst & en & !sync_rst & id_in_buf_valid & hash_in_valid & slot;
        ofire = en & m_valid & hash_out_ready;
        fl[0] = (hash_in_id != id_in_buf);
`ifdef SHA256_ID_VALIDATOR_LAST_CHECK_EN
        fl[1] = (id_in_buf_last != hash_in_last);
`else
        fl[1] = 1'b0;
`endif
        h  = hash_in;
        hl = hash_in_last;
        @(posedge clk);
        #1;
        if (sync_rst) begin
            model_clear();
            jn = 1'b0;
        end else begin
            if (jn) begin
                m_valid = 1'b1;
                m_hash  = h;
                m_err   = fl[0];
                m_last  = hl;
            end else if (ofire) begin
                m_valid = 1'b0;
            end
            if (status_clear) begin
                m_cnt  = jn ? 1 : 0;
                m_serr = jn ? fl : 2'b00;
            end else if (jn) begin
                m_cnt  = (m_cnt + 1) % 1024;
                m_serr = m_serr | fl;
            end
        end
        joined = jn;
        chk("out_valid", 256'(hash_out_valid), 256'(m_valid));
        if (m_valid) begin
            chk("out_hash", hash_out, m_hash);
            chk("out_err", 256'(hash_out_err), 256'(m_err));
            chk("out_last", 256'(hash_out_last), 256'(m_last));
        end
        chk("status_err", 256'(status_err), 256'(m_serr));
        chk("count", 256'(status_packet_count), 256'(m_cnt));
        @(negedge clk);
        if (joined) begin
            id_in_buf_valid = 1'b0;
            hash_in_valid   = 1'b0;
        end
    endtask

    task automatic pair(input logic [5:0] id, input logic [5:0] hid,
                        input logic l, input logic [255:0] h);
        id_in_buf       = id;
        id_in_buf_last  = l;
        id_in_buf_valid = 1'b1;
        hash_in         = h;
        hash_in_id      = hid;
        hash_in_last    = l;
        hash_in_valid   = 1'b1;
    endtask

    initial begin
        nrst            = 1'b0;
        en              = 1'b1;
        sync_rst        = 1'b0;
        status_clear    = 1'b0;
        hash_out_ready  = 1'b1;
        pair(6'd1, 6'd1, 1'b0, '1);
        model_clear();
        joined = 1'b0;

        // Reset state, with both valids high: readies must stay low.
        #2;
        chk("rst_id_ready", 256'(id_in_buf_ready), 256'(0));
        chk("rst_hash_ready", 256'(hash_in_ready), 256'(0));
        chk("rst_hash_out", hash_out, 256'(0));
        chk("rst_valid", 256'(hash_out_valid), 256'(0));
        chk("rst_err", 256'(hash_out_err), 256'(0));
        chk("rst_last", 256'(hash_out_last), 256'(0));
        chk("rst_status", 256'(status_err), 256'(0));
        chk("rst_count", 256'(status_packet_count), 256'(0));
        @(negedge clk);
        @(negedge clk);
        id_in_buf_valid = 1'b0;
        hash_in_valid   = 1'b0;
        nrst            = 1'b1;

        // Matched pair with last set.
        pair(6'd5, 6'd5, 1'b1, {64{4'hA}});
        tick();
        chk("t1_hash", hash_out, {64{4'hA}});
        chk("t1_err", 256'(hash_out_err), 256'(0));
        chk("t1_last", 256'(hash_out_last), 256'(1));
        chk("t1_count", 256'(status_packet_count), 256'(1));
        chk("t1_status", 256'(status_err), 256'(0));

        // ID mismatch, then a matching pair keeps the sticky flag.
        pair(6'd3, 6'd4, 1'b0, rand256());
        tick();
        chk("t2_err", 256'(hash_out_err), 256'(1));
        chk("t2_sticky", 256'(status_err[0]), 256'(1));
        pair(6'd7, 6'd7, 1'b0, rand256());
        tick();
        chk("t2_err_clr", 256'(hash_out_err), 256'(0));
        chk("t2_sticky_hold", 256'(status_err[0]), 256'(1));

        // Output stall with two pairs pending.
        tick();
        hash_out_ready = 1'b0;
        pair(6'd10, 6'd10, 1'b0, {64{4'h1}});
        tick();
        p2_hash = {64{4'h2}};
        pair(6'd11, 6'd11, 1'b0, p2_hash);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_stall_hash", hash_out, {64{4'h1}});
        end
        hash_out_ready = 1'b1;
        tick();
        chk("t3_second", hash_out, p2_hash);
        tick();

        // ID stream gap while the digest waits.
        hash_in         = rand256();
        hash_in_id      = 6'd20;
        hash_in_last    = 1'b0;
        hash_in_valid   = 1'b1;
        id_in_buf_valid = 1'b0;
        tick();
        tick();
        id_in_buf       = 6'd20;
        id_in_buf_last  = 1'b0;
        id_in_buf_valid = 1'b1;
        tick();
        chk("t4_joined", 256'(joined), 256'(1));

        // Count wrap after 1024 joins, then clear racing a join.
        status_clear = 1'b1;
        tick();
        status_clear = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            pair(6'(i), 6'(i), 1'b0, rand256());
            tick();
        end
        chk("t5_wrap", 256'(status_packet_count), 256'(0));
        status_clear = 1'b1;
        pair(6'd1, 6'd2, 1'b0, rand256());
        tick();
        status_clear = 1'b0;
        chk("t5_clear_join_cnt", 256'(status_packet_count), 256'(1));
        chk("t5_clear_join_err", 256'(status_err), 256'(1));

        // Synchronous reset with output valid.
        hash_out_ready = 1'b0;
        pair(6'd9, 6'd9, 1'b0, rand256());
        tick();
        sync_rst = 1'b1;
        tick();
        sync_rst = 1'b0;
        chk("t6_srst_valid", 256'(hash_out_valid), 256'(0));
        chk("t6_srst_count", 256'(status_packet_count), 256'(0));

        // Enable low freezes state; status_clear still works.
        tick();
        en = 1'b0;
        pair(6'd12, 6'd13, 1'b0, rand256());
        tick();
        tick();
        chk("t6_en_valid", 256'(hash_out_valid), 256'(1));
        status_clear = 1'b1;
        tick();
        status_clear = 1'b0;
        chk("t6_en_clear", 256'(status_packet_count), 256'(0));
        en = 1'b1;
        hash_out_ready = 1'b1;
        tick();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            en             = ($urandom_range(7) != 0);
            hash_out_ready = ($urandom_range(2) != 0);
            status_clear   = ($urandom_range(63) == 0);
            sync_rst       = ($urandom_range(199) == 0);
            if (!id_in_buf_valid && $urandom_range(3) != 0) begin
                id_in_buf_valid = 1'b1;
                id_in_buf       = 6'($urandom);
                id_in_buf_last  = 1'($urandom);
            end
            if (!hash_in_valid && $urandom_range(3) != 0) begin
                hash_in_valid = 1'b1;
                hash_in       = rand256();
                if (id_in_buf_valid && $urandom_range(3) != 0) begin
                    hash_in_id   = id_in_buf;
                    hash_in_last = id_in_buf_last;
                end else begin
                    hash_in_id   = 6'($urandom);
                    hash_in_last = 1'($urandom);
                end
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
